// File: rtl/doodlejump_key_pkg.sv
// Shared constants and types for the doodlejump push-button controller.
// Register word addresses, release-edge bit offset, debounce state, counter width.
package doodlejump_key_pkg;

   localparam logic [1:0] KEY_ADDR_DATA = 2'd0;
   localparam logic [1:0] KEY_ADDR_MASK = 2'd1;
   localparam logic [1:0] KEY_ADDR_EDGE = 2'd2;
   localparam logic [1:0] KEY_ADDR_RAW  = 2'd3;

   localparam int RELEASE_OFS = 16;

   typedef enum logic {
      DB_STABLE,
      DB_PENDING
   } db_state_e;

   // Width able to hold DEBOUNCE_CYCLES-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/doodlejump_key_debounce.sv
// One key: 2-flop synchronizer, stability counter and accepted level.
// Ports: clk, reset_n, pin (polarity-corrected), sync, stable, rise_pulse, fall_pulse.
module doodlejump_key_debounce
   import doodlejump_key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin,
   output logic sync,
   output logic stable,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   db_state_e     state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          stable_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         state  <= DB_STABLE;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         meta   <= pin;
         sync   <= meta;
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         stable <= stable_nxt;
      end
   end

   // The cycle that first sees a difference counts as the first
   // stable cycle, so the level is accepted after exactly
   // DEBOUNCE_CYCLES differing cycles.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      stable_nxt = stable;
      rise_pulse = 1'b0;
      fall_pulse = 1'b0;
      unique case (state)
         DB_STABLE: begin
            cnt_nxt = '0;
            if (sync != stable) begin
               state_nxt = DB_PENDING;
               cnt_nxt   = CW'(1);
            end
         end
         DB_PENDING: begin
            if (sync == stable) begin
               state_nxt = DB_STABLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt  = DB_STABLE;
               cnt_nxt    = '0;
               stable_nxt = sync;
               rise_pulse = sync;
               fall_pulse = ~sync;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
      endcase
   end

endmodule

// File: rtl/doodlejump_key_ctrl.sv
// Avalon-MM push-button controller: debounced levels, W1C edge capture, masked irq.
// Ports: clk, reset_n, address/read/write/writedata/readdata, in_port, irq.
// Optional DOODLEJUMP_KEY_RELEASE_EDGE_EN adds release edges/mask at bits [16+:NUM_KEYS].
module doodlejump_key_ctrl #(
   parameter int NUM_KEYS        = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          address,
   input  logic                read,
   input  logic                write,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   input  logic [NUM_KEYS-1:0] in_port,
   output logic                irq
);

   import doodlejump_key_pkg::*;

   logic [NUM_KEYS-1:0] pin_c, sync, stable, rise, fall;
   logic [NUM_KEYS-1:0] mask_lo, edge_lo, clr_lo;
   logic                wr_mask, wr_edge, irq_nxt;
   logic [31:0]         w_data, w_mask, w_edge, w_raw, rd_nxt;

   assign pin_c = (ACTIVE_LOW != 0) ? ~in_port : in_port;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      doodlejump_key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk       (clk),
         .reset_n   (reset_n),
         .pin       (pin_c[g]),
         .sync      (sync[g]),
         .stable    (stable[g]),
         .rise_pulse(rise[g]),
         .fall_pulse(fall[g])
      );
   end

   assign wr_mask = write && (address == KEY_ADDR_MASK);
   assign wr_edge = write && (address == KEY_ADDR_EDGE);
   assign clr_lo  = wr_edge ? writedata[NUM_KEYS-1:0] : '0;

   // New events are OR-ed after the clear so a same-cycle set wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_lo <= '0;
         edge_lo <= '0;
      end else begin
         if (wr_mask) mask_lo <= writedata[NUM_KEYS-1:0];
         edge_lo <= (edge_lo & ~clr_lo) | rise;
      end
   end

`ifdef DOODLEJUMP_KEY_RELEASE_EDGE_EN
   logic [NUM_KEYS-1:0] mask_hi, edge_hi, clr_hi;

   assign clr_hi = wr_edge ? writedata[RELEASE_OFS +: NUM_KEYS] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_hi <= '0;
         edge_hi <= '0;
      end else begin
         if (wr_mask) mask_hi <= writedata[RELEASE_OFS +: NUM_KEYS];
         edge_hi <= (edge_hi & ~clr_hi) | fall;
      end
   end

   assign irq_nxt = |(edge_lo & mask_lo) | |(edge_hi & mask_hi);

   // readdata is unconditional on read.
   logic unused_in;
   assign unused_in = &{1'b0, read, writedata};
`else
   assign irq_nxt = |(edge_lo & mask_lo);

   // Release pulses and upper write bits have no home here.
   logic unused_in;
   assign unused_in = &{1'b0, read, writedata, fall};
`endif

   always_comb begin
      w_data = '0;
      w_mask = '0;
      w_edge = '0;
      w_raw  = '0;
      w_data[NUM_KEYS-1:0] = stable;
      w_mask[NUM_KEYS-1:0] = mask_lo;
      w_edge[NUM_KEYS-1:0] = edge_lo;
      w_raw[NUM_KEYS-1:0]  = sync;
`ifdef DOODLEJUMP_KEY_RELEASE_EDGE_EN
      w_mask[RELEASE_OFS +: NUM_KEYS] = mask_hi;
      w_edge[RELEASE_OFS +: NUM_KEYS] = edge_hi;
`endif
      rd_nxt = '0;
      unique case (address)
         KEY_ADDR_DATA: rd_nxt = w_data;
         KEY_ADDR_MASK: rd_nxt = w_mask;
         KEY_ADDR_EDGE: rd_nxt = w_edge;
         KEY_ADDR_RAW:  rd_nxt = w_raw;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         readdata <= rd_nxt;
         irq      <= irq_nxt;
      end
   end

endmodule

// File: tb/tb_doodlejump_key_ctrl.sv
// Self-checking bench for doodlejump_key_ctrl (NUM_KEYS=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1).
// Honours DOODLEJUMP_KEY_RELEASE_EDGE_EN for the expected upper-half values.
module tb_doodlejump_key_ctrl;

   localparam int NK = 2;
   localparam int DC = 4;

`ifdef DOODLEJUMP_KEY_RELEASE_EDGE_EN
   localparam logic [31:0] M_ALL = 32'h0003_0003;
   localparam logic [31:0] M_B16 = 32'h0001_0001;
   localparam logic [31:0] E_REL = 32'h0001_0001;
`else
   localparam logic [31:0] M_ALL = 32'h0000_0003;
   localparam logic [31:0] M_B16 = 32'h0000_0001;
   localparam logic [31:0] E_REL = 32'h0000_0001;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    address;
   logic          read;
   logic          write;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [NK-1:0] in_port;
   logic          irq;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];
   string       nm_q[$];

   typedef struct {
      logic [1:0]  addr;
      logic        wr;
      logic [31:0] wd;
      logic [31:0] exp;
      string       nm;
   } vec_t;

   vec_t tbl[7];

   always #5 clk = ~clk;

   doodlejump_key_ctrl #(
      .NUM_KEYS(NK),
      .DEBOUNCE_CYCLES(DC),
      .ACTIVE_LOW(1)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .address(address),
      .read(read),
      .write(write),
      .writedata(writedata),
      .readdata(readdata),
      .in_port(in_port),
      .irq(irq)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Push the expectation when the address is driven; pop it when
   // the registered readdata appears one cycle later.
   task automatic rd(input logic [1:0] a, input logic [31:0] e,
                     input string nm);
      logic [31:0] ex;
      string       n;
      address = a;
      read    = 1'b1;
      exp_q.push_back(e);
      nm_q.push_back(nm);
      tick();
      read = 1'b0;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         ex = exp_q.pop_front();
         n  = nm_q.pop_front();
         chk(n, readdata, ex);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write     = 1'b1;
      tick();
      write     = 1'b0;
      writedata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{KEY_A(1), 1'b1, 32'hFFFF_FFFF, M_ALL, "mask_all"};
      tbl[1] = '{KEY_A(1), 1'b1, 32'h0000_0002, 32'h2, "mask_b1"};
      tbl[2] = '{KEY_A(1), 1'b1, 32'h0001_0001, M_B16, "mask_b16"};
      tbl[3] = '{KEY_A(0), 1'b1, 32'hFFFF_FFFF, 32'h0, "data_ro"};
      tbl[4] = '{KEY_A(3), 1'b1, 32'hFFFF_FFFF, 32'h0, "raw_ro"};
      tbl[5] = '{KEY_A(2), 1'b1, 32'hFFFF_FFFF, 32'h0, "edge_w1c_idle"};
      tbl[6] = '{KEY_A(1), 1'b1, 32'h0000_0000, 32'h0, "mask_zero"};

      reset_n   = 1'b0;
      address   = 2'd0;
      read      = 1'b0;
      write     = 1'b0;
      writedata = '0;
      in_port   = 2'b11;
      ticks(3);
      reset_n = 1'b1;

      chk("reset_irq", {31'd0, irq}, 32'h0);
      for (int a = 0; a < 4; a++)
         rd(2'(a), 32'h0, $sformatf("reset_addr%0d", a));

      for (int i = 0; i < 7; i++) begin
         if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wd);
         rd(tbl[i].addr, tbl[i].exp, tbl[i].nm);
      end

      // Press key 0: stable after 2+DC edges, visible one read later.
      address    = 2'd0;
      in_port[0] = 1'b0;
      ticks(2 + DC);
      chk("press_lat_pre", readdata, 32'h0);
      tick();
      chk("press_lat", readdata, 32'h1);
      rd(2'd2, 32'h1, "press_edge");
      rd(2'd3, 32'h1, "press_raw");

      // Glitch one cycle shorter than the debounce window.
      in_port[1] = 1'b0;
      ticks(DC - 1);
      in_port[1] = 1'b1;
      ticks(8);
      rd(2'd0, 32'h1, "glitch_data");
      rd(2'd2, 32'h1, "glitch_edge");

      wr(2'd2, 32'h1);
      rd(2'd2, 32'h0, "w1c_clear");

      // Masked press on key 1.
      wr(2'd1, 32'h3);
      chk("irq_mask_only", {31'd0, irq}, 32'h0);
      address    = 2'd2;
      in_port[1] = 1'b0;
      ticks(2 + DC);
      chk("irq_pre", {31'd0, irq}, 32'h0);
      chk("edge1_pre", readdata, 32'h0);
      tick();
      chk("irq_rise", {31'd0, irq}, 32'h1);
      chk("edge1_set", readdata, 32'h2);
      wr(2'd2, 32'h2);
      chk("irq_hold", {31'd0, irq}, 32'h1);
      tick();
      chk("irq_fall", {31'd0, irq}, 32'h0);
      rd(2'd2, 32'h0, "edge1_clr");

      // Release key 0, then re-press with a W1C on the event cycle.
      in_port[0] = 1'b1;
      ticks(8);
      wr(2'd2, 32'hFFFF_FFFF);
      chk("irq_idle", {31'd0, irq}, 32'h0);
      in_port[0] = 1'b0;
      ticks(1 + DC);
      address   = 2'd2;
      writedata = 32'h1;
      write     = 1'b1;
      tick();
      write     = 1'b0;
      writedata = '0;
      tick();
      chk("setwin_irq", {31'd0, irq}, 32'h1);
      rd(2'd2, 32'h1, "setwin_edge");
      chk("setwin_irq_hold", {31'd0, irq}, 32'h1);

      // Release key 0: release edge only with the optional feature.
      in_port[0] = 1'b1;
      ticks(8);
      rd(2'd2, E_REL, "release_edge");

      // Reset part-way through a debounce of key 0.
      address    = 2'd0;
      in_port[0] = 1'b0;
      ticks(3);
      reset_n = 1'b0;
      tick();
      chk("rst_mid_rd", readdata, 32'h0);
      chk("rst_mid_irq", {31'd0, irq}, 32'h0);
      reset_n = 1'b1;
      ticks(2 + DC);
      chk("rst_relat_pre", readdata, 32'h0);
      tick();
      chk("rst_relat", readdata, 32'h3);
      rd(2'd2, 32'h3, "rst_edge");
      chk("rst_irq_masked", {31'd0, irq}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   function automatic logic [1:0] KEY_A(input int a);
      return 2'(a);
   endfunction

endmodule
